// File: rtl/es8psk_pkg.sv
// Shared constants, half-filter coefficient table and FSM type for the
// 1090ES/8PSK transmit pulse-shaping FIR.
package es8psk_pkg;

  localparam int DW        = 20;
  localparam int CW        = 18;
  localparam int NTAPS     = 45;
  localparam int COEF_FRAC = 17;
  localparam int NH        = (NTAPS + 1) / 2;
  localparam int KW        = $clog2(NH);
  localparam int XW        = $clog2(NTAPS);
  localparam int PW        = DW + 1;
  localparam int MW        = DW + CW + 1;
  localparam int AW        = MW + $clog2(NH);

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [PW-1:0] preadd_t;
  typedef logic signed [MW-1:0] prod_t;
  typedef logic signed [AW-1:0] acc_t;

  // Windowed half-band, outermost tap first; 2*sum(c[0..NH-2]) + c[NH-1] = 2^COEF_FRAC.
  localparam coef_t SHAPE_COEF [0:NH-1] = '{
    18'sd0,      18'sd193,    18'sd0,      -18'sd323,
    18'sd0,      18'sd555,    18'sd0,      -18'sd913,
    18'sd0,      18'sd1432,   18'sd0,      -18'sd2167,
    18'sd0,      18'sd3218,   18'sd0,      -18'sd4800,
    18'sd0,      18'sd7483,   18'sd0,      -18'sd13377,
    18'sd0,      18'sd41467,  18'sd65536
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ROUND = 2'd3
  } fir_state_e;

  localparam logic signed [AW:0] RND_BIAS =
    {{(AW-COEF_FRAC+1){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [AW:0] Y_MAX = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] Y_MIN = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  // Round half up by the coefficient scale, then clamp to the sample range.
  function automatic sample_t round_sat(input acc_t acc);
    logic signed [AW:0] biased;
    logic signed [AW:0] shifted;
    sample_t            y;
    biased  = {acc[AW-1], acc} + RND_BIAS;
    shifted = biased >>> COEF_FRAC;
    if (shifted > Y_MAX) begin
      y = Y_MAX[DW-1:0];
    end else if (shifted < Y_MIN) begin
      y = Y_MIN[DW-1:0];
    end else begin
      y = shifted[DW-1:0];
    end
    return y;
  endfunction

endpackage

// File: rtl/shape_fir_coef_rom.sv
// Registered coefficient lookup for the shaping FIR; one-cycle read latency
// lines up with the registered pre-adder output.
module shape_fir_coef_rom
  import es8psk_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [KW-1:0] addr,
  output coef_t         coef
);

  // Coefficient read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      coef <= '0;
    end else if (addr <= KW'(NH - 1)) begin
      coef <= SHAPE_COEF[addr];
    end else begin
      coef <= '0;
    end
  end

endmodule

// File: rtl/shape_fir_iq.sv
// Symmetric 45-tap I/Q pulse-shaping FIR: one serial pre-add/MAC per rail,
// shared control, round-half-up and saturation back to DW bits.
module shape_fir_iq
  import es8psk_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  input  logic                 ena_in,
  output logic signed [DW-1:0] dout_i,
  output logic signed [DW-1:0] dout_q,
  output logic                 ena_out,
  output logic                 busy,
  output logic                 overrun
);

  fir_state_e    state_r, state_s;
  logic [KW-1:0] k_r, k_s;
  logic          flush_r, flush_s;
  logic          accept_s;
  logic          mac_busy_s;
  logic          centre_s;
  logic [XW-1:0] kx_s;
  logic [XW-1:0] mirror_s;

  sample_t xi_r [0:NTAPS-1];
  sample_t xq_r [0:NTAPS-1];

  preadd_t pre_i_s, pre_q_s;
  preadd_t pre_i_r, pre_q_r;
  coef_t   coef_r;
  prod_t   prod_i_r, prod_q_r;
  logic    v1_r, v2_r;
  acc_t    acc_i_r, acc_q_r;

  // ROUND only reads the accumulator, so a new pass may start in that cycle.
  assign accept_s   = ena_in && ((state_r == ST_IDLE) || (state_r == ST_ROUND));
  assign mac_busy_s = (state_r == ST_MAC) || (state_r == ST_FLUSH);
  assign centre_s   = (k_r == KW'(NH - 1));
  assign kx_s       = XW'(k_r);
  assign mirror_s   = XW'(NTAPS - 1) - kx_s;

  shape_fir_coef_rom u_coef_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (k_r),
    .coef  (coef_r)
  );

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      k_r     <= '0;
      flush_r <= 1'b0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      flush_r <= flush_s;
    end
  end

  // Next-state logic: tap index walk, two flush cycles, then round.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    flush_s = flush_r;
    case (state_r)
      ST_IDLE: begin
        if (ena_in) begin
          state_s = ST_MAC;
          k_s     = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (centre_s) begin
          state_s = ST_FLUSH;
          flush_s = 1'b0;
        end else begin
          k_s = k_r + KW'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_r) begin
          state_s = ST_ROUND;
        end else begin
          flush_s = 1'b1;
        end
      end
      ST_ROUND: begin
        if (ena_in) begin
          state_s = ST_MAC;
          k_s     = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        k_s     = '0;
        flush_s = 1'b0;
      end
    endcase
  end

  // Delay lines shift only when a sample is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NTAPS; j++) begin
        xi_r[j] <= '0;
        xq_r[j] <= '0;
      end
    end else if (accept_s) begin
      xi_r[0] <= din_i;
      xq_r[0] <= din_q;
      for (int j = 1; j < NTAPS; j++) begin
        xi_r[j] <= xi_r[j-1];
        xq_r[j] <= xq_r[j-1];
      end
    end
  end

  // Symmetric pre-add; the centre tap has no mirror partner.
  always_comb begin
    pre_i_s = '0;
    pre_q_s = '0;
    if (centre_s) begin
      pre_i_s = PW'(xi_r[kx_s]);
      pre_q_s = PW'(xq_r[kx_s]);
    end else begin
      pre_i_s = PW'(xi_r[kx_s]) + PW'(xi_r[mirror_s]);
      pre_q_s = PW'(xq_r[kx_s]) + PW'(xq_r[mirror_s]);
    end
  end

  // Pre-add and multiply pipeline with a valid tag per stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_i_r  <= '0;
      pre_q_r  <= '0;
      prod_i_r <= '0;
      prod_q_r <= '0;
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
    end else begin
      pre_i_r  <= pre_i_s;
      pre_q_r  <= pre_q_s;
      v1_r     <= (state_r == ST_MAC);
      prod_i_r <= MW'(pre_i_r) * MW'(coef_r);
      prod_q_r <= MW'(pre_q_r) * MW'(coef_r);
      v2_r     <= v1_r;
    end
  end

  // Accumulators restart on every accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_i_r <= '0;
      acc_q_r <= '0;
    end else if (accept_s) begin
      acc_i_r <= '0;
      acc_q_r <= '0;
    end else if (v2_r) begin
      acc_i_r <= acc_i_r + AW'(prod_i_r);
      acc_q_r <= acc_q_r + AW'(prod_q_r);
    end
  end

  // Output registers, strobe and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_i  <= '0;
      dout_q  <= '0;
      ena_out <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ena_out <= (state_r == ST_ROUND);
      busy    <= (state_s == ST_MAC) || (state_s == ST_FLUSH);
      if (state_r == ST_ROUND) begin
        dout_i <= round_sat(acc_i_r);
        dout_q <= round_sat(acc_q_r);
      end
      if (ena_in && mac_busy_s) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shape_fir_iq.sv
// Bench for shape_fir_iq: directed scenarios and random samples checked
// against a direct-form 45-tap convolution model.
module tb_shape_fir_iq;

  localparam int NT   = 45;
  localparam int HALF = 23;
  localparam int COEF_H [0:HALF-1] = '{0, 193, 0, -323, 0, 555, 0, -913, 0, 1432, 0, -2167,
                                       0, 3218, 0, -4800, 0, 7483, 0, -13377, 0, 41467, 65536};

  logic               clk = 1'b0;
  logic               reset;
  logic signed [19:0] din_i, din_q;
  logic               ena_in;
  logic signed [19:0] dout_i, dout_q;
  logic               ena_out, busy, overrun;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint xi_m [0:NT-1];
  longint xq_m [0:NT-1];
  longint exp_i, exp_q;

  always #5 clk = ~clk;

  shape_fir_iq dut (
    .clk     (clk),
    .reset   (reset),
    .din_i   (din_i),
    .din_q   (din_q),
    .ena_in  (ena_in),
    .dout_i  (dout_i),
    .dout_q  (dout_q),
    .ena_out (ena_out),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic check_val(input string tag, input longint obs, input longint want);
    n_checks++;
    if (obs !== want) $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    else n_pass++;
  endtask

  function automatic longint cfull(input int j);
    return longint'(COEF_H[(j < HALF) ? j : (NT - 1 - j)]);
  endfunction

  function automatic longint fir_ref(input bit use_q);
    longint acc = 0;
    longint y;
    for (int j = 0; j < NT; j++) acc += cfull(j) * (use_q ? xq_m[j] : xi_m[j]);
    y = (acc + 65536) >>> 17;
    if (y > 524287) y = 524287;
    else if (y < -524288) y = -524288;
    return y;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < NT; j++) begin
      xi_m[j] = 0;
      xq_m[j] = 0;
    end
  endtask

  task automatic model_push(input int si, input int sq);
    for (int j = NT - 1; j > 0; j--) begin
      xi_m[j] = xi_m[j-1];
      xq_m[j] = xq_m[j-1];
    end
    xi_m[0] = si;
    xq_m[0] = sq;
    exp_i = fir_ref(1'b0);
    exp_q = fir_ref(1'b1);
  endtask

  // Called #1 after the edge at which the sample was taken.
  task automatic wait_out();
    int lat  = 0;
    bit seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = ena_out;
    end
    check_val("latency", lat, 26);
    check_val("dout_i", dout_i, exp_i);
    check_val("dout_q", dout_q, exp_q);
  endtask

  task automatic send(input int si, input int sq);
    model_push(si, sq);
    din_i  = 20'(si);
    din_q  = 20'(sq);
    ena_in = 1'b1;
    @(posedge clk); #1;
    ena_in = 1'b0;
    wait_out();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int pulses;
    int s;
    longint e1i, e1q;

    reset  = 1'b1;
    din_i  = '0;
    din_q  = '0;
    ena_in = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_dout_i", dout_i, 0);
    check_val("rst_dout_q", dout_q, 0);
    check_val("rst_ena_out", ena_out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Impulse response reproduces the coefficients
    for (int n = 0; n < NT; n++) begin
      send((n == 0) ? 131072 : 0, 0);
      check_val("impulse_i", dout_i, cfull(n));
      check_val("impulse_q", dout_q, 0);
    end

    // DC gain is exactly one once the line is full
    for (int n = 0; n < 60; n++) begin
      send(1000, 1000);
      if (n >= NT - 1) begin
        check_val("dc_i", dout_i, 1000);
        check_val("dc_q", dout_q, 1000);
      end
    end

    // Sign-matched full scale saturates without wrapping
    for (int n = 0; n < NT; n++) begin
      s = (cfull(NT - 1 - n) > 0) ? 1 : ((cfull(NT - 1 - n) < 0) ? -1 : 0);
      send(s * 524287, -s * 524287);
    end
    check_val("sat_pos_i", dout_i, 524287);
    check_val("sat_neg_q", dout_q, -524288);

    // Latency, overrun drop, and restart in the output cycle
    model_push(12345, -54321);
    e1i = exp_i;
    e1q = exp_q;
    din_i = 20'(12345); din_q = -20'(54321); ena_in = 1'b1;
    @(posedge clk); #1;
    ena_in = 1'b0;
    check_val("busy_set", busy, 1);
    repeat (9) @(posedge clk);
    #1;
    check_val("ovr_before", overrun, 0);
    din_i = 20'(300000); din_q = 20'(300000); ena_in = 1'b1;
    @(posedge clk); #1;
    ena_in = 1'b0;
    check_val("ovr_set", overrun, 1);
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ena_out) pulses++;
    end
    check_val("no_early_out", pulses, 0);
    model_push(-77777, 88888);
    din_i = -20'(77777); din_q = 20'(88888); ena_in = 1'b1;
    @(posedge clk); #1;
    ena_in = 1'b0;
    check_val("ovr_out_strobe", ena_out, 1);
    check_val("ovr_dout_i", dout_i, e1i);
    check_val("ovr_dout_q", dout_q, e1q);
    check_val("restart_busy", busy, 1);
    wait_out();
    check_val("ovr_sticky", overrun, 1);
    send(4242, -4242);

    // Reset in the middle of a pass
    din_i = 20'(200000); din_q = 20'(200000); ena_in = 1'b1;
    @(posedge clk); #1;
    ena_in = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_dout_i", dout_i, 0);
    check_val("mid_rst_dout_q", dout_q, 0);
    check_val("mid_rst_ena_out", ena_out, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_overrun", overrun, 0);
    reset = 1'b0;
    model_clear();
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ena_out) pulses++;
    end
    check_val("aborted_no_out", pulses, 0);
    for (int n = 0; n < NT; n++) begin
      send((n == 0) ? 131072 : 0, 0);
      check_val("post_rst_imp_i", dout_i, cfull(n));
    end

    // Rounding at the centre tap: +1 rounds up, -1 rounds to zero
    do_reset();
    for (int n = 0; n < HALF; n++) begin
      if (n == 0) send(1, -1);
      else send(0, 0);
    end
    check_val("round_up_i", dout_i, 1);
    check_val("round_half_q", dout_q, 0);

    // Random samples with random idle gaps
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(int'($urandom_range(0, 1048575)) - 524288,
           int'($urandom_range(0, 1048575)) - 524288);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
